// File: rtl/counter_reader.sv
// Snapshot FIFO that captures a live 8-bit counter on request, with first-word-fall-through read.
// Optional wrap-around event counter is included when COUNTER_READER_WRAP_EN is defined.
module counter_reader #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    data_cnt,
    input  logic          snap,
    input  logic          rd,
    output logic [7:0]    rdata,
    output logic          rvalid,
    output logic          full,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic [7:0]    wrap_cnt
);

    localparam int unsigned LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic          push;
    logic          pop;
    logic          drop;
    logic [LW-1:0] level_next;

    // A full FIFO still accepts a capture when the same edge pops the head.
    always_comb begin
        push       = 1'b0;
        pop        = 1'b0;
        drop       = 1'b0;
        level_next = level;
        pop  = rd && rvalid;
        push = snap && (!full || rd);
        drop = snap && full && !rd;
        unique case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rvalid <= 1'b0;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level  <= level_next;
            rvalid <= (level_next != '0);
            full   <= (level_next == LW'(DEPTH));
            if (drop) ovf <= 1'b1;
        end
    end

    // Storage is data-path only; reset leaves it untouched.
    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= data_cnt;
    end

    assign rdata = mem[rd_ptr];

`ifdef COUNTER_READER_WRAP_EN
    logic [7:0] prev_cnt;

    // A wrap is an FF -> 00 transition between consecutive samples; count saturates.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_cnt <= 8'h00;
            wrap_cnt <= 8'h00;
        end else begin
            prev_cnt <= data_cnt;
            if (prev_cnt == 8'hFF && data_cnt == 8'h00 && wrap_cnt != 8'hFF)
                wrap_cnt <= wrap_cnt + 8'd1;
        end
    end
`else
    assign wrap_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_counter_reader.sv
// Directed self-checking bench for counter_reader (DEPTH=4); wrap checks follow COUNTER_READER_WRAP_EN.
module tb_counter_reader;

    logic       clk;
    logic       reset;
    logic [7:0] data_cnt;
    logic       snap;
    logic       rd;
    logic [7:0] rdata;
    logic       rvalid;
    logic       full;
    logic [2:0] level;
    logic       ovf;
    logic [7:0] wrap_cnt;

    int passed = 0;
    int total  = 0;

    counter_reader #(.DEPTH(4), .AW(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_cnt (data_cnt),
        .snap     (snap),
        .rd       (rd),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .full     (full),
        .level    (level),
        .ovf      (ovf),
        .wrap_cnt (wrap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Advance one edge; inputs set after this return are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; snap = 1'b0; rd = 1'b0; data_cnt = 8'h00;
        step(); step();
        reset = 1'b0;
        check("rst_level",  32'(level),    32'd0);
        check("rst_rvalid", 32'(rvalid),   32'd0);
        check("rst_full",   32'(full),     32'd0);
        check("rst_ovf",    32'(ovf),      32'd0);
        check("rst_wrap",   32'(wrap_cnt), 32'd0);

        // Single capture and pop.
        snap = 1'b1; data_cnt = 8'h55; step(); snap = 1'b0;
        check("one_rvalid", 32'(rvalid), 32'd1);
        check("one_rdata",  32'(rdata),  32'h55);
        check("one_level",  32'(level),  32'd1);
        rd = 1'b1; step(); rd = 1'b0;
        check("pop_rvalid", 32'(rvalid), 32'd0);
        check("pop_level",  32'(level),  32'd0);

        // Five captures into a four-entry FIFO: last one dropped.
        for (int i = 0; i < 5; i++) begin
            snap = 1'b1; data_cnt = 8'(8'h10 + i); step();
        end
        snap = 1'b0;
        check("ovf_full",  32'(full),  32'd1);
        check("ovf_level", 32'(level), 32'd4);
        check("ovf_flag",  32'(ovf),   32'd1);
        check("ovf_head",  32'(rdata), 32'h10);

        // Full with simultaneous push and pop.
        snap = 1'b1; rd = 1'b1; data_cnt = 8'hA0; step(); snap = 1'b0; rd = 1'b0;
        check("sp_level", 32'(level), 32'd4);
        check("sp_ovf",   32'(ovf),   32'd1);
        check("sp_full",  32'(full),  32'd1);
        check("sp_head",  32'(rdata), 32'h11);
        check("pop0", 32'(rdata), 32'h11); rd = 1'b1; step();
        check("pop1", 32'(rdata), 32'h12); step();
        check("pop2", 32'(rdata), 32'h13); step();
        check("pop3", 32'(rdata), 32'hA0); step(); rd = 1'b0;
        check("drain_level",  32'(level),  32'd0);
        check("drain_rvalid", 32'(rvalid), 32'd0);
        check("ovf_sticky",   32'(ovf),    32'd1);

        // Reset clears ovf; reads while empty have no effect.
        reset = 1'b1; step(); reset = 1'b0;
        check("rst2_ovf", 32'(ovf), 32'd0);
        rd = 1'b1; step(); step(); step(); rd = 1'b0;
        check("empty_rd_level",  32'(level),  32'd0);
        check("empty_rd_rvalid", 32'(rvalid), 32'd0);
        check("empty_rd_ovf",    32'(ovf),    32'd0);

        // Full push+pop with ovf clear keeps ovf clear and order intact.
        for (int i = 0; i < 4; i++) begin
            snap = 1'b1; data_cnt = 8'(8'h30 + i); step();
        end
        snap = 1'b1; rd = 1'b1; data_cnt = 8'hB0; step(); snap = 1'b0; rd = 1'b0;
        check("sp2_level", 32'(level), 32'd4);
        check("sp2_ovf",   32'(ovf),   32'd0);
        check("sp2_head",  32'(rdata), 32'h31);
        rd = 1'b1; step(); step(); step();
        check("sp2_last", 32'(rdata), 32'hB0);
        step(); rd = 1'b0;
        check("sp2_empty", 32'(level), 32'd0);

        // Push+pop while empty: push only.
        snap = 1'b1; rd = 1'b1; data_cnt = 8'h61; step();
        check("empty_sp_level", 32'(level), 32'd1);
        check("empty_sp_data",  32'(rdata), 32'h61);
        // Push+pop at level 1: level unchanged, head replaced.
        data_cnt = 8'h62; step(); snap = 1'b0; rd = 1'b0;
        check("mid_sp_level", 32'(level), 32'd1);
        check("mid_sp_data",  32'(rdata), 32'h62);

        // Reset wins over snap/rd with entries stored.
        snap = 1'b1; data_cnt = 8'h63; step(); snap = 1'b0;
        check("pre_rst_level", 32'(level), 32'd2);
        reset = 1'b1; snap = 1'b1; rd = 1'b1; data_cnt = 8'h64; step();
        reset = 1'b0; snap = 1'b0; rd = 1'b0;
        check("rst3_level",  32'(level),  32'd0);
        check("rst3_rvalid", 32'(rvalid), 32'd0);
        check("rst3_ovf",    32'(ovf),    32'd0);
        snap = 1'b1; data_cnt = 8'h77; step(); snap = 1'b0;
        check("post_rst_level", 32'(level), 32'd1);
        check("post_rst_data",  32'(rdata), 32'h77);
        rd = 1'b1; step(); rd = 1'b0;

        // Wrap detection.
        data_cnt = 8'hFE; step();
        data_cnt = 8'hFF; step();
        data_cnt = 8'h00; step();
        data_cnt = 8'h01; step();
`ifdef COUNTER_READER_WRAP_EN
        check("wrap_one", 32'(wrap_cnt), 32'd1);
`else
        check("wrap_off_one", 32'(wrap_cnt), 32'd0);
`endif
        for (int i = 0; i < 300; i++) begin
            data_cnt = 8'hFF; step();
            data_cnt = 8'h00; step();
        end
`ifdef COUNTER_READER_WRAP_EN
        check("wrap_sat", 32'(wrap_cnt), 32'hFF);
`else
        check("wrap_off_sat", 32'(wrap_cnt), 32'd0);
`endif
        check("wrap_no_push", 32'(level), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
